// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers (polynomial 0x11B).
package aes_pkg;

  // Number of columns in the AES state; the iterative MixColumns is built for exactly this.
  localparam int unsigned AES_NUM_COLS = 4;

  // Cipher direction. Any other encoding is illegal and is flagged by the consumer.
  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

  // Sparse encoding: every pair of legal states is at Hamming distance >= 3,
  // so a single upset can never turn one legal state into another.
  typedef enum logic [4:0] {
    IDLE = 5'b10110,
    BUSY = 5'b01101,
    DONE = 5'b11000
  } aes_mix_iter_state_e;

  // Multiply by x (0x02) in GF(2^8) mod 0x11B.
  function automatic logic [7:0] aes_mul2(input logic [7:0] x);
    logic [7:0] r;
    r = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  // Multiply by x^2 (0x04) in GF(2^8) mod 0x11B.
  function automatic logic [7:0] aes_mul4(input logic [7:0] x);
    return aes_mul2(aes_mul2(x));
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational (Inv)MixColumns on one 4-byte column, data_i[0..3] = rows 0..3.
// The inverse is computed as a cheap pre-multiply by the circulant {05,00,04,00}
// followed by the forward matrix, so both directions share one multiplier tree.
module aes_mix_single_column
  import aes_pkg::*;
(
  input  ciph_op_e         op_i,
  input  logic [3:0][7:0]  data_i,
  output logic [3:0][7:0]  data_o
);

  logic [3:0][7:0] pre_s;
  logic [7:0]      u_s;
  logic [7:0]      v_s;

  // Inverse pre-processing: a0^=4(a0^a2), a2^=4(a0^a2), a1^=4(a1^a3), a3^=4(a1^a3).
  always_comb begin
    pre_s = data_i;
    u_s   = 8'h00;
    v_s   = 8'h00;
    if (op_i == CIPH_INV) begin
      u_s      = aes_mul4(data_i[0] ^ data_i[2]);
      v_s      = aes_mul4(data_i[1] ^ data_i[3]);
      pre_s[0] = data_i[0] ^ u_s;
      pre_s[2] = data_i[2] ^ u_s;
      pre_s[1] = data_i[1] ^ v_s;
      pre_s[3] = data_i[3] ^ v_s;
    end else begin
      pre_s = data_i;
    end
  end

  // Forward matrix: out[r] = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] = 2*(a[r]^a[r+1]) ^ a[r+1] ^ a[r+2] ^ a[r+3].
  always_comb begin
    data_o = '0;
    for (int r = 0; r < 4; r++) begin
      data_o[r] = aes_mul2(pre_s[r] ^ pre_s[(r + 1) & 3])
                ^ pre_s[(r + 1) & 3] ^ pre_s[(r + 2) & 3] ^ pre_s[(r + 3) & 3];
    end
  end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns: one column per cycle through a single column mixer,
// full 4x4 state in and out over valid/ready. Result and valid come from flops.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NumCols = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  ciph_op_e               op_i,
  input  logic [3:0][3:0][7:0]   state_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [3:0][3:0][7:0]   state_o,
  output logic                   err_o
);

  if (NumCols != AES_NUM_COLS) begin : gen_bad_numcols
    $error("aes_mix_columns_iter: NumCols must be 4");
  end

  aes_mix_iter_state_e  fsm_q, fsm_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [3:0][3:0][7:0] work_q, work_d;
  ciph_op_e             op_q, op_d;
  logic                 op_err_q, op_err_d;
  logic                 err_q, err_d;

  logic [3:0][7:0]      col_in_s;
  logic [3:0][7:0]      col_out_s;
  logic                 accept_s;
  logic                 op_ok_s;

  aes_mix_single_column u_mix_col (
    .op_i   (op_q),
    .data_i (col_in_s),
    .data_o (col_out_s)
  );

  // Select the column addressed by the counter as the mixer operand.
  always_comb begin
    col_in_s = '0;
    for (int r = 0; r < 4; r++) begin
      col_in_s[r] = work_q[r][cnt_q];
    end
  end

  // Handshake decode; in DONE a new state is taken only while the result is drained.
  always_comb begin
    in_ready_o = 1'b0;
    if (fsm_q == IDLE) begin
      in_ready_o = 1'b1;
    end else if (fsm_q == DONE) begin
      in_ready_o = out_ready_i;
    end else begin
      in_ready_o = 1'b0;
    end
    accept_s = in_valid_i & in_ready_o;
    op_ok_s  = (op_i == CIPH_FWD) || (op_i == CIPH_INV);
  end

  // Next-state logic: accept, per-column writeback, drain, abort.
  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    op_d     = op_q;
    op_err_d = op_err_q;
    err_d    = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (accept_s) begin
          work_d   = state_i;
          op_d     = op_i;
          op_err_d = ~op_ok_s;
          err_d    = ~op_ok_s;
          cnt_d    = 2'd0;
          fsm_d    = BUSY;
        end else begin
          fsm_d = IDLE;
        end
      end
      BUSY: begin
        // An illegal op still walks all four columns but writes zeros,
        // so no partially mixed data can ever be presented.
        for (int r = 0; r < 4; r++) begin
          work_d[r][cnt_q] = op_err_q ? 8'h00 : col_out_s[r];
        end
        if (cnt_q == 2'd3) begin
          cnt_d = 2'd0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          if (accept_s) begin
            work_d   = state_i;
            op_d     = op_i;
            op_err_d = ~op_ok_s;
            err_d    = ~op_ok_s;
            cnt_d    = 2'd0;
            fsm_d    = BUSY;
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        // Corrupted state register: recover to IDLE, scrub data, report.
        fsm_d    = IDLE;
        cnt_d    = 2'd0;
        work_d   = '0;
        op_err_d = 1'b0;
        err_d    = 1'b1;
      end
    endcase

    if (clear_i) begin
      fsm_d    = IDLE;
      cnt_d    = 2'd0;
      work_d   = '0;
      op_d     = CIPH_FWD;
      op_err_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      err_d = err_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q    <= IDLE;
      cnt_q    <= 2'd0;
      work_q   <= '0;
      op_q     <= CIPH_FWD;
      op_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op_q     <= op_d;
      op_err_q <= op_err_d;
      err_q    <= err_d;
    end
  end

  assign out_valid_o = (fsm_q == DONE);
  assign state_o     = work_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Self-checking bench for aes_mix_columns_iter: vector table, hand sequences,
// and random FWD/INV round trips against a matrix-based GF(2^8) model.
module tb_aes_mix_columns_iter;
  import aes_pkg::*;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef struct {
    ciph_op_e op;
    state_t   din;
    state_t   exp;
  } vec_t;

  logic     clk_i = 1'b0;
  logic     rst_i, clear_i, in_valid_i, out_ready_i;
  logic     in_ready_o, out_valid_o, err_o;
  ciph_op_e op_i;
  state_t   state_i, state_o;

  int n_tests = 0;
  int n_fail  = 0;

  aes_mix_columns_iter #(.NumCols(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .state_i     (state_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic state_t model_mix(input ciph_op_e op, input state_t s);
    logic [7:0] m [4];
    state_t o;
    o = '0;
    if (op == CIPH_FWD) begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end else if (op == CIPH_INV) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      return o;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[r][c] = o[r][c] ^ gmul(m[(k - r + 4) % 4], s[k][c]);
    return o;
  endfunction

  function automatic state_t mk(input logic [31:0] c0, input logic [31:0] cr);
    state_t s;
    logic [31:0] col;
    for (int c = 0; c < 4; c++) begin
      col = (c == 0) ? c0 : cr;
      for (int r = 0; r < 4; r++) s[r][c] = col[31 - 8 * r -: 8];
    end
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int r = 0; r < 4; r++) s[r] = $urandom;
    return s;
  endfunction

  // ---------------- checkers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Present a state and return #1 after the accepting edge.
  task automatic send(input ciph_op_e op, input state_t st);
    int guard;
    op_i = op; state_i = st; in_valid_i = 1'b1;
    guard = 0;
    while (!in_ready_o && guard < 20) begin
      @(posedge clk_i); #1; guard++;
    end
    check_bit("send_ready", in_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  // Full transaction with out_ready_i high; lat = edges from accept to out_valid.
  task automatic do_xact(input ciph_op_e op, input state_t din, output state_t res, output int lat);
    logic bad_op;
    bad_op = !(op == CIPH_FWD || op == CIPH_INV);
    out_ready_i = 1'b1;
    send(op, din);
    check_bit("err_pulse", err_o, bad_op);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1; lat++;
      if (lat == 1) check_bit("err_one_cycle", err_o, 1'b0);
      if (lat == 2) check_bit("busy_not_ready", in_ready_o, 1'b0);
    end
    check_bit("out_valid_seen", out_valid_o, 1'b1);
    res = state_o;
    @(posedge clk_i); #1;
    check_bit("out_valid_drop", out_valid_o, 1'b0);
  endtask

  vec_t   vecs[6];
  state_t res, res2, rs, held;
  int     lat;
  logic   seen;

  initial begin
    vecs[0] = '{CIPH_FWD, mk(32'hdb135345, 32'h01010101), mk(32'h8e4da1bc, 32'h01010101)};
    vecs[1] = '{CIPH_INV, mk(32'h8e4da1bc, 32'h01010101), mk(32'hdb135345, 32'h01010101)};
    vecs[2] = '{CIPH_FWD, mk(32'hd4bf5d30, 32'hc6c6c6c6), mk(32'h046681e5, 32'hc6c6c6c6)};
    vecs[3] = '{CIPH_INV, mk(32'hc6c6c6c6, 32'hc6c6c6c6), mk(32'hc6c6c6c6, 32'hc6c6c6c6)};
    vecs[4] = '{ciph_op_e'(2'b00), mk(32'hdb135345, 32'h01010101), '0};
    vecs[5] = '{ciph_op_e'(2'b11), mk(32'hd4bf5d30, 32'hc6c6c6c6), '0};

    rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_i = CIPH_FWD; state_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_bit("rst_in_ready", in_ready_o, 1'b1);
    check_bit("rst_out_valid", out_valid_o, 1'b0);
    check_bit("rst_err", err_o, 1'b0);
    check_state("rst_state", state_o, '0);

    // Table: known vectors, latency of 4 edges (accept cycle + 4 BUSY cycles).
    for (int i = 0; i < 6; i++) begin
      do_xact(vecs[i].op, vecs[i].din, res, lat);
      check_state("table_result", res, vecs[i].exp);
      check_int("table_latency", lat, 4);
    end

    // Output hold under backpressure.
    out_ready_i = 1'b0;
    send(CIPH_FWD, vecs[2].din);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1; lat++;
    end
    check_int("hold_latency", lat, 4);
    held = state_o;
    check_state("hold_result", held, vecs[2].exp);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_i); #1;
      check_bit("hold_valid", out_valid_o, 1'b1);
      check_bit("hold_in_ready", in_ready_o, 1'b0);
      check_state("hold_state", state_o, held);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check_bit("hold_release", out_valid_o, 1'b0);

    // Back-to-back: in_valid held high, one result every 5 cycles.
    begin
      state_t bb[3];
      int sent, got, last;
      logic acc;
      for (int i = 0; i < 3; i++) bb[i] = rand_state();
      sent = 0; got = 0; last = 0;
      op_i = CIPH_FWD; state_i = bb[0]; in_valid_i = 1'b1; out_ready_i = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
        acc = in_valid_i & in_ready_o;
        if (out_valid_o) begin
          check_state("b2b_result", state_o, model_mix(CIPH_FWD, bb[got]));
          if (got > 0) check_int("b2b_spacing", cyc - last, 5);
          last = cyc;
          got++;
        end
        @(posedge clk_i); #1;
        if (acc) begin
          sent++;
          if (sent < 3) state_i = bb[sent];
          else in_valid_i = 1'b0;
        end
      end
      check_int("b2b_count", got, 3);
      in_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end

    // Abort during BUSY cycle 2: first with clear_i, then with rst_i.
    for (int pass = 0; pass < 2; pass++) begin
      rs = rand_state();
      send(CIPH_FWD, rs);
      @(posedge clk_i); #1;
      if (pass == 0) clear_i = 1'b1; else rst_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0; rst_i = 1'b0;
      check_bit("abort_in_ready", in_ready_o, 1'b1);
      check_bit("abort_out_valid", out_valid_o, 1'b0);
      check_state("abort_scrub", state_o, '0);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk_i); #1;
        if (out_valid_o) seen = 1'b1;
      end
      check_bit("abort_no_result", seen, 1'b0);
      rs = rand_state();
      do_xact(CIPH_INV, rs, res, lat);
      check_state("abort_next_result", res, model_mix(CIPH_INV, rs));
    end

    // Random FWD against model, then INV round trip.
    for (int i = 0; i < 100; i++) begin
      rs = rand_state();
      do_xact(CIPH_FWD, rs, res, lat);
      check_state("rand_fwd", res, model_mix(CIPH_FWD, rs));
      do_xact(CIPH_INV, res, res2, lat);
      check_state("rand_roundtrip", res2, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
